shape_processor_engine: RTL and testbench

- Parametrised shape processor: CTRL SFR (SHAPE, OPERATION) plus a multi-cycle compute engine working on N-bit side operands.
- Sits behind the SFR bus as a single-register peripheral.
- Takes operand jobs over a valid/ready handshake and returns results over valid/ready.
- Generalises side width, computes real results (perimeter, area, shape predicates), and applies the legality rules in hardware.

---
 rtl/shape_processor_pkg.sv | 71 +++++++
 rtl/shape_processor_mult.sv | 75 +++++++
 rtl/shape_processor_engine.sv | 174 +++++++++++++++++
 tb/tb_shape_processor_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/shape_processor_pkg.sv
// Shared types and legality helpers for the shape processor.
// CTRL register layout (ctrl_sfr_reg):
//   [31]    err_clr   - write 1 on an accepted write to clear the sticky error
//                       (SHAPE_PROCESSOR_ENGINE_ERR_EN builds only); never stored
//   [30:18] reserved, read 0
//   [17:16] shape     - shape_e
//   [15:3]  reserved, read 0
//   [2:0]   operation - operation_e
package shape_processor_pkg;

  typedef enum logic [1:0] {
    KEEP_SHAPE = 2'd0,
    RECTANGLE  = 2'd1,
    TRIANGLE   = 2'd2,
    SHAPE_RSVD = 2'd3
  } shape_e;

  typedef enum logic [2:0] {
    PERIMETER      = 3'd0,
    AREA           = 3'd1,
    IS_SQUARE      = 3'd2,
    IS_EQUILATERAL = 3'd3,
    IS_ISOSCELES   = 3'd4,
    OP_RSVD5       = 3'd5,
    OP_RSVD6       = 3'd6,
    OP_RSVD7       = 3'd7
  } operation_e;

  typedef struct packed {
    logic        err_clr;
    logic [12:0] rsvd_hi;
    shape_e      shape;
    logic [12:0] rsvd_lo;
    operation_e  operation;
  } ctrl_sfr_reg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam ctrl_sfr_reg CTRL_RESET = '{err_clr: 1'b0, rsvd_hi: 13'd0, shape: RECTANGLE,
                                         rsvd_lo: 13'd0, operation: PERIMETER};

  // KEEP_SHAPE is a legal write value: it means "leave SHAPE as it is".
  function automatic logic is_legal_shape(input shape_e s);
    case (s)
      KEEP_SHAPE, RECTANGLE, TRIANGLE: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_operation(input operation_e op);
    case (op)
      PERIMETER, AREA, IS_SQUARE, IS_EQUILATERAL, IS_ISOSCELES: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  // s is the effective shape (KEEP_SHAPE already resolved).
  function automatic logic is_legal_combination(input shape_e s, input operation_e op);
    case (op)
      PERIMETER, AREA:              return (s == RECTANGLE) || (s == TRIANGLE);
      IS_SQUARE:                    return (s == RECTANGLE);
      IS_EQUILATERAL, IS_ISOSCELES: return (s == TRIANGLE);
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shape_processor_mult.sv
// Sequential shift-add multiplier. start_i loads the operands and already
// consumes multiplier bit 0; the remaining bits take one cycle each, so the
// product is ready after exactly DATA_W clock edges. done_o pulses for one
// cycle and product_o then holds until the next start_i.
// Ports: clk, rst_n, start_i, a_i, b_i (DATA_W), done_o, product_o (2*DATA_W).
module shape_processor_mult #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   product_o
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d;

  // Next-state: load on start, otherwise one shift-add step per busy cycle.
  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start_i) begin
      mcand_d  = {{DATA_W{1'b0}}, a_i} << 1;
      mplier_d = b_i >> 1;
      prod_d   = b_i[0] ? {{DATA_W{1'b0}}, a_i} : {2*DATA_W{1'b0}};
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      prod_d   = prod_q + (mplier_q[0] ? mcand_q : {2*DATA_W{1'b0}});
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= {2*DATA_W{1'b0}};
      prod_q   <= {2*DATA_W{1'b0}};
      mplier_q <= {DATA_W{1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = prod_q;
endmodule

// File: rtl/shape_processor_engine.sv
// Shape processor: one CTRL SFR (SHAPE, OPERATION) with hardware legality
// checks, plus an IDLE->CALC->DONE engine computing perimeter, area and
// shape predicates on DATA_W-bit unsigned sides.
// Ports: clk, rst_n; sfr_write_en/sfr_write_data/sfr_read_data (CTRL access);
//        start_valid/start_ready + side_a/b/c (job in);
//        res_valid/res_ready/res_data (result out, RES_W bits).
// Optional macro SHAPE_PROCESSOR_ENGINE_ERR_EN adds sticky err_o (rejected
// write), mirrored on sfr_read_data[31].
module shape_processor_engine
  import shape_processor_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sfr_write_en,
  input  logic [31:0]       sfr_write_data,
  output logic [31:0]       sfr_read_data,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] side_a,
  input  logic [DATA_W-1:0] side_b,
  input  logic [DATA_W-1:0] side_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data
`ifdef SHAPE_PROCESSOR_ENGINE_ERR_EN
  ,
  output logic              err_o
`endif
);
  ctrl_sfr_reg         ctrl_q, ctrl_d, wr_s;
  shape_e              eff_shape_s, job_shape_q;
  operation_e          job_op_q;
  state_e              state_q, state_d;
  logic                wr_ok_s, accept_s, mult_done_s;
  logic [DATA_W-1:0]   a_q, b_q, c_q;
  logic [RES_W-1:0]    res_q, res_d, single_res_s;
  logic [2*DATA_W-1:0] product_s;
  logic                unused_wr_bits_s;

  assign unused_wr_bits_s = ^{sfr_write_data[30:18], sfr_write_data[15:3]};

  // CTRL write decode: whole write accepted or dropped, KEEP_SHAPE resolved first.
  always_comb begin
    wr_s        = ctrl_sfr_reg'(sfr_write_data);
    eff_shape_s = (wr_s.shape == KEEP_SHAPE) ? ctrl_q.shape : wr_s.shape;
    wr_ok_s     = sfr_write_en && is_legal_shape(wr_s.shape) &&
                  is_legal_operation(wr_s.operation) &&
                  is_legal_combination(eff_shape_s, wr_s.operation);
    ctrl_d      = ctrl_q;
    if (wr_ok_s) begin
      ctrl_d           = CTRL_RESET;
      ctrl_d.shape     = eff_shape_s;
      ctrl_d.operation = wr_s.operation;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  assign accept_s = start_valid && (state_q == ST_IDLE);

  shape_processor_mult #(.DATA_W(DATA_W)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept_s && (ctrl_q.operation == AREA)),
    .a_i       (side_a),
    .b_i       (side_b),
    .done_o    (mult_done_s),
    .product_o (product_s)
  );

  // Single-cycle results from the latched job operands.
  always_comb begin
    single_res_s = {RES_W{1'b0}};
    case (job_op_q)
      PERIMETER:
        if (job_shape_q == TRIANGLE) begin
          single_res_s = RES_W'(a_q) + RES_W'(b_q) + RES_W'(c_q);
        end else begin
          single_res_s = (RES_W'(a_q) + RES_W'(b_q)) << 1;
        end
      IS_SQUARE:      single_res_s[0] = (a_q == b_q);
      IS_EQUILATERAL: single_res_s[0] = (a_q == b_q) && (b_q == c_q);
      IS_ISOSCELES:   single_res_s[0] = (a_q == b_q) || (b_q == c_q) || (a_q == c_q);
      default:        single_res_s = {RES_W{1'b0}};
    endcase
  end

  // Engine next-state and result capture.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE:
        if (accept_s) state_d = ST_CALC;
        else          state_d = ST_IDLE;
      ST_CALC:
        if (job_op_q != AREA) begin
          state_d = ST_DONE;
          res_d   = single_res_s;
        end else if (mult_done_s) begin
          state_d = ST_DONE;
          // Triangle area is base*height/2, floored.
          res_d   = (job_shape_q == TRIANGLE) ? RES_W'(product_s >> 1) : RES_W'(product_s);
        end else begin
          state_d = ST_CALC;
        end
      ST_DONE:
        if (res_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, CTRL and job snapshot registers; snapshot uses CTRL before any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= CTRL_RESET;
      res_q       <= {RES_W{1'b0}};
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      c_q         <= {DATA_W{1'b0}};
      job_op_q    <= PERIMETER;
      job_shape_q <= RECTANGLE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      if (accept_s) begin
        a_q         <= side_a;
        b_q         <= side_b;
        c_q         <= side_c;
        job_op_q    <= ctrl_q.operation;
        job_shape_q <= ctrl_q.shape;
      end
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign res_data    = res_q;

`ifdef SHAPE_PROCESSOR_ENGINE_ERR_EN
  logic err_q, err_d;

  // Sticky error: set by a rejected write, cleared by an accepted write with bit 31 set.
  always_comb begin
    err_d = err_q;
    if (sfr_write_en && !wr_ok_s) begin
      err_d = 1'b1;
    end else if (wr_ok_s && wr_s.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o         = err_q;
  assign sfr_read_data = {err_q, ctrl_q[30:0]};
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = sfr_write_data[31];
  assign sfr_read_data    = {1'b0, ctrl_q[30:0]};
`endif
endmodule

// File: tb/tb_shape_processor_engine.sv
module tb_shape_processor_engine;
  localparam int DATA_W = 16;
  localparam int RES_W  = 2 * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sfr_write_en;
  logic [31:0]       sfr_write_data;
  logic [31:0]       sfr_read_data;
  logic              start_valid;
  logic              start_ready;
  logic [DATA_W-1:0] side_a, side_b, side_c;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
`ifdef SHAPE_PROCESSOR_ENGINE_ERR_EN
  logic              err_o;
`endif

  int vectors    = 0;
  int miscompares = 0;

  shape_processor_engine #(.DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sfr_write_en   (sfr_write_en),
    .sfr_write_data (sfr_write_data),
    .sfr_read_data  (sfr_read_data),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .side_a         (side_a),
    .side_b         (side_b),
    .side_c         (side_c),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data)
`ifdef SHAPE_PROCESSOR_ENGINE_ERR_EN
    ,
    .err_o          (err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CTRL bits 30:0; bit 31 is checked separately where it matters.
  task automatic check_ctrl(input string tag, input logic [31:0] exp);
    check(tag, {33'd0, sfr_read_data[30:0]}, {33'd0, exp[30:0]});
  endtask

  task automatic sfr_write(input logic [31:0] data);
    sfr_write_en   = 1'b1;
    sfr_write_data = data;
    tick();
    sfr_write_en   = 1'b0;
    sfr_write_data = 32'd0;
  endtask

  // Wait for res_valid; cyc counts cycles with the accept cycle as 0.
  task automatic wait_res(input string tag, input int exp_lat);
    int cyc;
    cyc = 1;
    while (res_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic do_job(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [31:0] exp_res, input int exp_lat);
    check({tag, " start_ready"}, {63'd0, start_ready}, 64'd1);
    side_a = a; side_b = b; side_c = c;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    wait_res(tag, exp_lat);
    check({tag, " res_data"}, {32'd0, res_data}, {32'd0, exp_res});
    tick();
    check({tag, " back to idle"}, {63'd0, start_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; sfr_write_en = 1'b0; sfr_write_data = 32'd0;
    start_valid = 1'b0; res_ready = 1'b1;
    side_a = 16'd0; side_b = 16'd0; side_c = 16'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check_ctrl("reset ctrl", 32'h0001_0000);
    check("reset start_ready", {63'd0, start_ready}, 64'd1);
    check("reset res_valid", {63'd0, res_valid}, 64'd0);
    check("reset res_data", {32'd0, res_data}, 64'd0);

    // Legality of CTRL writes
    sfr_write(32'h0002_0002);   // TRIANGLE + IS_SQUARE
    check_ctrl("reject tri/square", 32'h0001_0000);
    sfr_write(32'h0003_0000);   // reserved shape
    check_ctrl("reject shape 3", 32'h0001_0000);
    sfr_write(32'h0001_0005);   // reserved operation
    check_ctrl("reject op 5", 32'h0001_0000);
    sfr_write(32'h0000_0001);   // KEEP_SHAPE + AREA
    check_ctrl("keep/area", 32'h0001_0001);

    // Area
    do_job("rect area", 16'd300, 16'd500, 16'd0, 32'd150000, 17);
    sfr_write(32'h0002_0001);
    check_ctrl("tri/area", 32'h0002_0001);
    do_job("tri area", 16'd7, 16'd3, 16'd0, 32'd10, 17);

    // Predicates and triangle perimeter
    sfr_write(32'h0000_0004);
    check_ctrl("keep/iso", 32'h0002_0004);
    do_job("iso 5,9,5", 16'd5, 16'd9, 16'd5, 32'd1, 2);
    do_job("iso 4,5,6", 16'd4, 16'd5, 16'd6, 32'd0, 2);
    sfr_write(32'h0000_0003);
    do_job("equi 6,6,6", 16'd6, 16'd6, 16'd6, 32'd1, 2);
    do_job("equi 6,6,5", 16'd6, 16'd6, 16'd5, 32'd0, 2);
    sfr_write(32'h0000_0000);
    check_ctrl("keep/perim", 32'h0002_0000);
    do_job("tri perim", 16'd3, 16'd4, 16'd5, 32'd12, 2);

    // Rectangle perimeter at max sides with back-pressure
    sfr_write(32'h0001_0000);
    res_ready = 1'b0;
    side_a = 16'hFFFF; side_b = 16'hFFFF; side_c = 16'd7;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    wait_res("max perim", 2);
    for (int i = 0; i < 5; i++) begin
      check("held res_data", {32'd0, res_data}, 64'h3_FFFC);
      check("held res_valid", {63'd0, res_valid}, 64'd1);
      check("held start_ready", {63'd0, start_ready}, 64'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("ready after handshake", {63'd0, start_ready}, 64'd1);

    // Accept in the cycle after handshake, with a same-cycle CTRL write
    side_a = 16'd2; side_b = 16'd3; side_c = 16'd0;
    start_valid = 1'b1;
    sfr_write_en = 1'b1; sfr_write_data = 32'h0001_0002;
    tick();
    start_valid = 1'b0; sfr_write_en = 1'b0; sfr_write_data = 32'd0;
    check_ctrl("write during accept", 32'h0001_0002);
    wait_res("snapshot", 2);
    check("snapshot res_data", {32'd0, res_data}, 64'd10);
    tick();
    do_job("square 4,4", 16'd4, 16'd4, 16'd0, 32'd1, 2);

    // Reset in the middle of an area job
    sfr_write(32'h0001_0001);
    side_a = 16'd300; side_b = 16'd500;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midreset res_valid", {63'd0, res_valid}, 64'd0);
    check("midreset start_ready", {63'd0, start_ready}, 64'd1);
    check("midreset res_data", {32'd0, res_data}, 64'd0);
    check_ctrl("midreset ctrl", 32'h0001_0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Bit 31 behaviour
`ifdef SHAPE_PROCESSOR_ENGINE_ERR_EN
    check("err after reset", {63'd0, err_o}, 64'd0);
    sfr_write(32'h0003_0000);
    check("err set", {63'd0, err_o}, 64'd1);
    check("err readback", {32'd0, sfr_read_data}, 64'h8001_0000);
    sfr_write(32'h0001_0001);
    check("err kept", {32'd0, sfr_read_data}, 64'h8001_0001);
    sfr_write(32'h8001_0000);
    check("err cleared", {63'd0, err_o}, 64'd0);
    check("clear readback", {32'd0, sfr_read_data}, 64'h0001_0000);
`else
    sfr_write(32'h8003_0000);
    check("bit31 after reject", {32'd0, sfr_read_data}, 64'h0001_0000);
    sfr_write(32'h8001_0001);
    check("bit31 after accept", {32'd0, sfr_read_data}, 64'h0001_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
